// File: rtl/rat_multi.sv
// Multi-lane register alias table: renames NLANES sources per cycle, tracks producer tags,
// accepts tag-matched writebacks and restores committed values on flush.
module rat_multi #(
   parameter int NREGS  = 32,
   parameter int XLEN   = 32,
   parameter int TAGW   = 7,
   parameter int NLANES = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NLANES-1:0]        rename_valid,
   input  logic [NLANES*(AW+1)-1:0] rename_rd,
   input  logic [NLANES*TAGW-1:0]   rename_robid,
   input  logic [NLANES*AW-1:0]     rename_rs1,
   input  logic [NLANES*AW-1:0]     rename_rs2,
   output logic [NLANES-1:0]        rat_rs1_valid,
   output logic [NLANES*XLEN-1:0]   rat_rs1_tagval,
   output logic [NLANES-1:0]        rat_rs2_valid,
   output logic [NLANES*XLEN-1:0]   rat_rs2_tagval,
   input  logic                     wb_valid,
   input  logic                     wb_error,
   input  logic [TAGW-1:0]          wb_robid,
   input  logic [AW:0]              wb_rd,
   input  logic [XLEN-1:0]          wb_result,
   input  logic                     rob_flush,
   input  logic                     rob_ret_valid,
   input  logic [TAGW-1:0]          rob_ret_robid,
   input  logic [AW:0]              rob_ret_rd,
   input  logic [XLEN-1:0]          rob_ret_result
);
   typedef enum logic [1:0] {ST_COMMIT, ST_PEND, ST_DONE} st_e;

   logic [XLEN-1:0] comm_val_q [NREGS];
   logic [XLEN-1:0] comm_val_d [NREGS];
   logic [XLEN-1:0] spec_val_q [NREGS];
   logic [XLEN-1:0] spec_val_d [NREGS];
   logic [TAGW-1:0] tag_q      [NREGS];
   logic [TAGW-1:0] tag_d      [NREGS];
   st_e             st_q       [NREGS];
   st_e             st_d       [NREGS];

   logic [AW:0]     rn_rd  [NLANES];
   logic [TAGW-1:0] rn_id  [NLANES];
   logic [AW-1:0]   rn_rs1 [NLANES];
   logic [AW-1:0]   rn_rs2 [NLANES];

   logic          wb_ok;
   logic [AW-1:0] wb_idx;
   logic          ret_ok;
   logic [AW-1:0] ret_idx;

   always_comb begin
      for (int i = 0; i < NLANES; i++) begin
         rn_rd[i]  = rename_rd[i*(AW+1) +: AW+1];
         rn_id[i]  = rename_robid[i*TAGW +: TAGW];
         rn_rs1[i] = rename_rs1[i*AW +: AW];
         rn_rs2[i] = rename_rs2[i*AW +: AW];
      end
   end

   assign wb_idx  = wb_rd[AW-1:0];
   assign wb_ok   = wb_valid & ~wb_error & wb_rd[AW];
   assign ret_idx = rob_ret_rd[AW-1:0];
   assign ret_ok  = rob_ret_valid & rob_ret_rd[AW] & (ret_idx != '0);

   // Later assignments override earlier ones, so statements run from lowest to highest priority.
   function automatic logic [XLEN:0] resolve(input int lane, input logic [AW-1:0] src);
      logic [XLEN:0] r;
      r = {1'b1, comm_val_q[src]};
      case (st_q[src])
         ST_DONE: r = {1'b1, spec_val_q[src]};
         ST_PEND: r = {1'b0, XLEN'(tag_q[src])};
         default: ;
      endcase
      if (wb_ok && wb_idx == src && wb_robid == tag_q[src] && st_q[src] == ST_PEND)
         r = {1'b1, wb_result};
      for (int j = 0; j < NLANES; j++) begin
         if (j < lane && rename_valid[j] && rn_rd[j][AW] && rn_rd[j][AW-1:0] == src)
            r = {1'b0, XLEN'(rn_id[j])};
      end
      if (src == '0)
         r = {1'b1, {XLEN{1'b0}}};
      return r;
   endfunction

   always_comb begin
      logic [XLEN:0] r1;
      logic [XLEN:0] r2;
      rat_rs1_valid  = '0;
      rat_rs1_tagval = '0;
      rat_rs2_valid  = '0;
      rat_rs2_tagval = '0;
      r1 = '0;
      r2 = '0;
      for (int i = 0; i < NLANES; i++) begin
         r1 = resolve(i, rn_rs1[i]);
         r2 = resolve(i, rn_rs2[i]);
         rat_rs1_valid[i]                = r1[XLEN];
         rat_rs1_tagval[i*XLEN +: XLEN]  = r1[XLEN-1:0];
         rat_rs2_valid[i]                = r2[XLEN];
         rat_rs2_tagval[i*XLEN +: XLEN]  = r2[XLEN-1:0];
      end
   end

   // Same-register order within a cycle: retire, then writeback, then rename (highest lane last).
   always_comb begin
      comm_val_d = comm_val_q;
      spec_val_d = spec_val_q;
      tag_d      = tag_q;
      st_d       = st_q;
      for (int r = 1; r < NREGS; r++) begin
         if (ret_ok && ret_idx == AW'(r)) begin
            comm_val_d[r] = rob_ret_result;
            if (rob_ret_robid == tag_q[r] && st_q[r] != ST_COMMIT)
               st_d[r] = ST_COMMIT;
         end
         if (rob_flush) begin
            st_d[r] = ST_COMMIT;
         end else begin
            if (wb_ok && wb_idx == AW'(r) && wb_robid == tag_q[r] && st_d[r] == ST_PEND) begin
               spec_val_d[r] = wb_result;
               st_d[r]       = ST_DONE;
            end
            for (int j = 0; j < NLANES; j++) begin
               if (rename_valid[j] && rn_rd[j][AW] && rn_rd[j][AW-1:0] == AW'(r)) begin
                  tag_d[r] = rn_id[j];
                  st_d[r]  = ST_PEND;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            comm_val_q[r] <= '0;
            spec_val_q[r] <= '0;
            tag_q[r]      <= '0;
            st_q[r]       <= ST_COMMIT;
         end
      end else begin
         comm_val_q <= comm_val_d;
         spec_val_q <= spec_val_d;
         tag_q      <= tag_d;
         st_q       <= st_d;
      end
   end
endmodule

// File: tb/tb_rat_multi.sv
// Bench for rat_multi: directed vector table for the rename/writeback/retire/flush corners,
// then randomized traffic checked against a behavioural per-register model.
module tb_rat_multi;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rename_valid;
   logic [11:0] rename_rd;
   logic [13:0] rename_robid;
   logic [9:0]  rename_rs1;
   logic [9:0]  rename_rs2;
   logic [1:0]  rat_rs1_valid;
   logic [63:0] rat_rs1_tagval;
   logic [1:0]  rat_rs2_valid;
   logic [63:0] rat_rs2_tagval;
   logic        wb_valid;
   logic        wb_error;
   logic [6:0]  wb_robid;
   logic [5:0]  wb_rd;
   logic [31:0] wb_result;
   logic        rob_flush;
   logic        rob_ret_valid;
   logic [6:0]  rob_ret_robid;
   logic [5:0]  rob_ret_rd;
   logic [31:0] rob_ret_result;

   rat_multi dut (
      .clk(clk), .rst(rst),
      .rename_valid(rename_valid), .rename_rd(rename_rd), .rename_robid(rename_robid),
      .rename_rs1(rename_rs1), .rename_rs2(rename_rs2),
      .rat_rs1_valid(rat_rs1_valid), .rat_rs1_tagval(rat_rs1_tagval),
      .rat_rs2_valid(rat_rs2_valid), .rat_rs2_tagval(rat_rs2_tagval),
      .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid), .wb_rd(wb_rd),
      .wb_result(wb_result), .rob_flush(rob_flush), .rob_ret_valid(rob_ret_valid),
      .rob_ret_robid(rob_ret_robid), .rob_ret_rd(rob_ret_rd), .rob_ret_result(rob_ret_result)
   );

   always #5 clk = ~clk;

   int nchk  = 0;
   int npass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Model state: committed value, speculative value, producer tag, mode 0=commit 1=pending 2=done
   logic [31:0] m_cv  [32];
   logic [31:0] m_sv  [32];
   logic [6:0]  m_tag [32];
   int          m_st  [32];

   function automatic logic [32:0] m_read(input int lane, input logic [4:0] src);
      logic [5:0] rrd;
      if (src == 5'd0) return {1'b1, 32'h0};
      for (int j = lane - 1; j >= 0; j--) begin
         rrd = rename_rd[j*6 +: 6];
         if (rename_valid[j] && rrd[5] && rrd[4:0] == src)
            return {1'b0, 25'h0, rename_robid[j*7 +: 7]};
      end
      if (wb_valid && !wb_error && wb_rd[5] && wb_rd[4:0] == src &&
          wb_robid == m_tag[src] && m_st[src] == 1)
         return {1'b1, wb_result};
      if (m_st[src] == 0) return {1'b1, m_cv[src]};
      if (m_st[src] == 2) return {1'b1, m_sv[src]};
      return {1'b0, 25'h0, m_tag[src]};
   endfunction

   task automatic m_update();
      logic [5:0] rrd;
      int r;
      if (rst) begin
         for (int k = 0; k < 32; k++) begin
            m_cv[k] = 0; m_sv[k] = 0; m_tag[k] = 0; m_st[k] = 0;
         end
         return;
      end
      if (rob_ret_valid && rob_ret_rd[5] && rob_ret_rd[4:0] != 0) begin
         r = int'(rob_ret_rd[4:0]);
         m_cv[r] = rob_ret_result;
         if (rob_ret_robid == m_tag[r] && m_st[r] != 0) m_st[r] = 0;
      end
      if (rob_flush) begin
         for (int k = 0; k < 32; k++) m_st[k] = 0;
         return;
      end
      if (wb_valid && !wb_error && wb_rd[5] && wb_rd[4:0] != 0) begin
         r = int'(wb_rd[4:0]);
         if (wb_robid == m_tag[r] && m_st[r] == 1) begin
            m_sv[r] = wb_result;
            m_st[r] = 2;
         end
      end
      for (int j = 0; j < 2; j++) begin
         rrd = rename_rd[j*6 +: 6];
         if (rename_valid[j] && rrd[5] && rrd[4:0] != 0) begin
            m_tag[rrd[4:0]] = rename_robid[j*7 +: 7];
            m_st[rrd[4:0]]  = 1;
         end
      end
   endtask

   task automatic check_model(input string name);
      logic [32:0] e;
      for (int i = 0; i < 2; i++) begin
         e = m_read(i, rename_rs1[i*5 +: 5]);
         chk({name, ".rs1v"}, 32'(rat_rs1_valid[i]), 32'(e[32]));
         chk({name, ".rs1t"}, rat_rs1_tagval[i*32 +: 32], e[31:0]);
         e = m_read(i, rename_rs2[i*5 +: 5]);
         chk({name, ".rs2v"}, 32'(rat_rs2_valid[i]), 32'(e[32]));
         chk({name, ".rs2t"}, rat_rs2_tagval[i*32 +: 32], e[31:0]);
      end
   endtask

   task automatic tick(input string name);
      #1;
      if (!rst) check_model(name);
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   task automatic idle();
      rename_valid = 0; rename_rd = 0; rename_robid = 0; rename_rs1 = 0; rename_rs2 = 0;
      wb_valid = 0; wb_error = 0; wb_robid = 0; wb_rd = 0; wb_result = 0;
      rob_flush = 0; rob_ret_valid = 0; rob_ret_robid = 0; rob_ret_rd = 0; rob_ret_result = 0;
   endtask

   typedef struct packed {
      logic [1:0]  rv;
      logic [5:0]  rd0, rd1;
      logic [6:0]  id0, id1;
      logic [4:0]  s0, s1;
      logic        wbv, wbe;
      logic [6:0]  wbid;
      logic [5:0]  wbrd;
      logic [31:0] wbres;
      logic        fl, rtv;
      logic [6:0]  rtid;
      logic [5:0]  rtrd;
      logic [31:0] rtres;
      logic        ev0;
      logic [31:0] et0;
      logic        ev1;
      logic [31:0] et1;
   } vec_t;

   vec_t tbl[$];

   initial begin
      vec_t v;
      idle();
      rst = 1;
      @(negedge clk);
      tick("rst0");
      tick("rst1");
      rst = 0;
      for (int r = 0; r < 32; r++) begin
         rename_rs1 = {5'd0, 5'(r)};
         rename_rs2 = {5'(r), 5'd0};
         #1;
         chk("reset_v", 32'(rat_rs1_valid[0]), 32'd1);
         chk("reset_t", rat_rs1_tagval[31:0], 32'd0);
         chk("reset_v1", 32'(rat_rs2_valid[1]), 32'd1);
      end
      @(negedge clk);

      // Each row: inputs applied for one cycle; expected lane0/lane1 rs1 reads in that cycle.
      v='0; v.s0=5; v.ev0=1; v.ev1=1; tbl.push_back(v);
      v='0; v.rv=1; v.rd0=6'h23; v.id0=7'h11; v.s0=3; v.s1=3; v.ev0=1; v.et1=32'h11; tbl.push_back(v);
      v='0; v.wbv=1; v.wbid=7'h11; v.wbrd=6'h23; v.wbres=32'hDEAD; v.s0=3; v.s1=4; v.ev0=1; v.et0=32'hDEAD; v.ev1=1; tbl.push_back(v);
      v='0; v.s0=3; v.s1=3; v.ev0=1; v.et0=32'hDEAD; v.ev1=1; v.et1=32'hDEAD; tbl.push_back(v);
      v='0; v.rv=1; v.rd0=6'h24; v.id0=2; v.s0=4; v.s1=4; v.ev0=1; v.et1=2; tbl.push_back(v);
      v='0; v.rv=3; v.rd0=6'h26; v.id0=7; v.rd1=6'h26; v.id1=8; v.s0=4; v.s1=6; v.et0=2; v.et1=7; tbl.push_back(v);
      v='0; v.s0=6; v.s1=6; v.et0=8; v.et1=8; tbl.push_back(v);
      v='0; v.rv=1; v.rd0=6'h29; v.id0=1; v.s0=9; v.ev0=1; v.ev1=1; tbl.push_back(v);
      v='0; v.rv=1; v.rd0=6'h29; v.id0=2; v.s0=9; v.et0=1; v.ev1=1; tbl.push_back(v);
      v='0; v.wbv=1; v.wbid=1; v.wbrd=6'h29; v.wbres=32'h55; v.s0=9; v.et0=2; v.ev1=1; tbl.push_back(v);
      v='0; v.s0=9; v.s1=9; v.et0=2; v.et1=2; tbl.push_back(v);
      v='0; v.wbv=1; v.wbid=2; v.wbrd=6'h29; v.wbres=32'h66; v.s0=9; v.ev0=1; v.et0=32'h66; v.ev1=1; tbl.push_back(v);
      v='0; v.s0=9; v.ev0=1; v.et0=32'h66; v.ev1=1; tbl.push_back(v);
      v='0; v.rtv=1; v.rtid=7'h11; v.rtrd=6'h23; v.rtres=32'hDEAD; v.s0=3; v.ev0=1; v.et0=32'hDEAD; v.ev1=1; tbl.push_back(v);
      v='0; v.rv=1; v.rd0=6'h23; v.id0=7'h20; v.s0=3; v.s1=3; v.ev0=1; v.et0=32'hDEAD; v.et1=32'h20; tbl.push_back(v);
      v='0; v.fl=1; v.s0=3; v.et0=32'h20; v.ev1=1; tbl.push_back(v);
      v='0; v.s0=3; v.s1=9; v.ev0=1; v.et0=32'hDEAD; v.ev1=1; tbl.push_back(v);
      v='0; v.rv=1; v.rd0=6'h23; v.id0=7'h11; v.s0=3; v.ev0=1; v.et0=32'hDEAD; v.ev1=1; tbl.push_back(v);
      v='0; v.wbv=1; v.wbe=1; v.wbid=7'h11; v.wbrd=6'h23; v.wbres=32'h77; v.s0=3; v.et0=32'h11; v.ev1=1; tbl.push_back(v);
      v='0; v.s0=3; v.et0=32'h11; v.ev1=1; tbl.push_back(v);
      v='0; v.fl=1; v.rv=1; v.rd0=6'h23; v.id0=7'h30; v.s0=3; v.s1=3; v.et0=32'h11; v.et1=32'h30; tbl.push_back(v);
      v='0; v.s0=3; v.s1=3; v.ev0=1; v.et0=32'hDEAD; v.ev1=1; v.et1=32'hDEAD; tbl.push_back(v);
      v='0; v.rv=1; v.rd0=6'h20; v.id0=5; v.wbv=1; v.wbrd=6'h20; v.wbres=32'h12; v.ev0=1; v.ev1=1; tbl.push_back(v);
      v='0; v.rv=1; v.rd0=6'h2A; v.id0=3; v.s0=10; v.ev0=1; v.ev1=1; tbl.push_back(v);
      v='0; v.rv=1; v.rd0=6'h2A; v.id0=4; v.s0=10; v.et0=3; v.ev1=1; tbl.push_back(v);
      v='0; v.rtv=1; v.rtid=3; v.rtrd=6'h2A; v.rtres=32'h99; v.s0=10; v.et0=4; v.ev1=1; tbl.push_back(v);
      v='0; v.s0=10; v.et0=4; v.ev1=1; tbl.push_back(v);
      v='0; v.fl=1; v.s0=10; v.et0=4; v.ev1=1; tbl.push_back(v);
      v='0; v.s0=10; v.ev0=1; v.et0=32'h99; v.ev1=1; tbl.push_back(v);

      for (int k = 0; k < tbl.size(); k++) begin
         v = tbl[k];
         rename_valid = v.rv; rename_rd = {v.rd1, v.rd0}; rename_robid = {v.id1, v.id0};
         rename_rs1 = {v.s1, v.s0}; rename_rs2 = '0;
         wb_valid = v.wbv; wb_error = v.wbe; wb_robid = v.wbid; wb_rd = v.wbrd; wb_result = v.wbres;
         rob_flush = v.fl; rob_ret_valid = v.rtv; rob_ret_robid = v.rtid; rob_ret_rd = v.rtrd;
         rob_ret_result = v.rtres;
         #1;
         chk($sformatf("vec%0d.l0v", k), 32'(rat_rs1_valid[0]), 32'(v.ev0));
         chk($sformatf("vec%0d.l0t", k), rat_rs1_tagval[31:0], v.et0);
         chk($sformatf("vec%0d.l1v", k), 32'(rat_rs1_valid[1]), 32'(v.ev1));
         chk($sformatf("vec%0d.l1t", k), rat_rs1_tagval[63:32], v.et1);
         chk($sformatf("vec%0d.r0", k), {rat_rs2_tagval[31:1], rat_rs2_valid[0]}, 32'd1);
         tick($sformatf("vec%0d", k));
      end

      // Reset arriving mid-operation wipes pending state and drops a same-cycle rename.
      idle();
      rename_valid = 2'b01; rename_rd = {6'h0, 6'h25}; rename_robid = {7'h0, 7'h09};
      tick("mid_rn");
      rst = 1;
      rename_valid = 2'b01; rename_rd = {6'h0, 6'h27}; rename_robid = {7'h0, 7'h0A};
      tick("mid_rst");
      rst = 0;
      idle();
      rename_rs1 = {5'd7, 5'd5};
      #1;
      chk("midrst_r5v", 32'(rat_rs1_valid[0]), 32'd1);
      chk("midrst_r5t", rat_rs1_tagval[31:0], 32'd0);
      chk("midrst_r7v", 32'(rat_rs1_valid[1]), 32'd1);
      chk("midrst_r7t", rat_rs1_tagval[63:32], 32'd0);
      tick("mid_post");

      for (int c = 0; c < 3000; c++) begin
         logic [4:0] wi, ri;
         rst = ($urandom_range(0, 199) == 0);
         rename_valid = 2'($urandom);
         rename_rd    = {1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
                         1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7))};
         rename_robid = {7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
         rename_rs1   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         rename_rs2   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wi = 5'($urandom_range(0, 7));
         wb_valid  = ($urandom_range(0, 1) == 1);
         wb_error  = ($urandom_range(0, 7) == 0);
         wb_rd     = {1'($urandom_range(0, 7) != 0), wi};
         wb_robid  = ($urandom_range(0, 3) != 0) ? m_tag[wi] : 7'($urandom_range(0, 7));
         wb_result = $urandom;
         ri = 5'($urandom_range(0, 7));
         rob_ret_valid  = ($urandom_range(0, 2) == 0);
         rob_ret_rd     = {1'($urandom_range(0, 7) != 0), ri};
         rob_ret_robid  = ($urandom_range(0, 1) == 1) ? m_tag[ri] : 7'($urandom_range(0, 7));
         rob_ret_result = $urandom;
         rob_flush = ($urandom_range(0, 31) == 0);
         tick("rand");
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule

// File: doc/rat_multi.md
Name: rat_multi

Overview:
- Parametrised multi-lane register alias table for the out-of-order core; successor to the single-lane RAT.
- Renames NLANES instructions per cycle with intra-bundle dependency resolution.
- Accepts writebacks only from the current producer (ROB-id tag match).
- Restores committed state on ROB flush.
- Sits between rename and the reservation stations; fed by the writeback bus and ROB retire.

Parameters:
NREGS, 32, architectural register count (power of 2); AW = $clog2(NREGS)
XLEN, 32, data width
TAGW, 7, ROB-id (tag) width; TAGW <= XLEN
NLANES, 2, rename lanes per cycle

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rename_valid  in  NLANES  per-lane rename strobe
rename_rd  in  NLANES*(AW+1)  per-lane dest; MSB=writes-register flag, low AW=index
rename_robid  in  NLANES*TAGW  per-lane ROB id
rename_rs1  in  NLANES*AW  per-lane source 1
rename_rs2  in  NLANES*AW  per-lane source 2
rat_rs1_valid  out  NLANES  1=tagval holds value, 0=tagval holds tag
rat_rs1_tagval  out  NLANES*XLEN  value or zero-extended tag
rat_rs2_valid  out  NLANES  as rs1
rat_rs2_tagval  out  NLANES*XLEN  as rs1
wb_valid  in  1  writeback strobe
wb_error  in  1  writeback carries exception, no result
wb_robid  in  TAGW  producer ROB id
wb_rd  in  AW+1  dest (MSB=writes-register)
wb_result  in  XLEN  result
rob_flush  in  1  pipeline flush
rob_ret_valid  in  1  retire strobe
rob_ret_robid  in  TAGW  retiring ROB id
rob_ret_rd  in  AW+1  retiring dest (MSB=writes-register)
rob_ret_result  in  XLEN  retiring value

Behaviour:
- Per-register state: comm_val[XLEN], spec_val[XLEN], tag[TAGW], st ∈ {COMMIT, PEND, DONE}.
- Reset: all st=COMMIT, comm_val=0, spec_val=0, tag=0. After reset every read returns valid=1, value 0.
- Reads are combinational from current state (0-cycle latency); state updates on posedge.
- Source resolution, priority high→low:
  (a) Index 0: valid=1, value 0.
  (b) Older lane j<i in same bundle has rename_valid, rd MSB=1 and rd index == src: valid=0, tag=robid of the highest such j.
  (c) wb_valid & ~wb_error & wb_rd MSB & wb_rd index == src & wb_robid == tag[src] & st[src]==PEND: valid=1, value=wb_result (bypass).
  (d) st==COMMIT: comm_val; st==DONE: spec_val; st==PEND: valid=0, tag.
- Rename (lane valid & rd MSB & index!=0): tag<=robid, st<=PEND. Multiple lanes to the same rd: highest lane wins.
- Writeback (valid, ~error, MSB, index!=0, wb_robid==tag, st==PEND): spec_val<=result, st<=DONE.
  - Tag mismatch (stale producer): ignored.
  - wb_error: no state change.
- Retire (valid, MSB, index!=0): comm_val<=result always. If rob_ret_robid==tag and st!=COMMIT, st<=COMMIT.
- Same-cycle, same-register ordering: retire, then writeback, then rename. Rename overrides st/tag; comm_val still written by retire.
- rob_flush: all st<=COMMIT. Same-cycle renames and writebacks are discarded; same-cycle retire still updates comm_val.
- Reset mid-operation overrides all other inputs that cycle.
- Writes to index 0 are dropped everywhere.

Test Plan:
- Reset, read rs1=5,rs2=0 lane0 -> valid=1/1, tagval=0/0.
- Rename lane0 rd=3 robid=0x11 -> next cycle read r3 gives valid=0, tagval=0x11. wb robid=0x11 rd=3 result=0xDEAD -> same-cycle read valid=1, 0xDEAD (bypass); next cycle 0xDEAD from spec_val.
- Bundle: lane0 rd=4 robid=2, lane1 rs1=4 -> lane1 valid=0, tagval=2. Both lanes rd=6 robids 7,8 -> r6 tag=8.
- Stale writeback: rename r9 robid=1, then robid=2; wb robid=1 result=0x55 -> r9 stays PEND, tag 2. wb robid=2 0x66 -> DONE, 0x66.
- Retire r3 robid=0x11 result=0xDEAD, then rename r3 robid=0x20, then flush -> read r3 valid=1, 0xDEAD.
- wb_error robid=0x11 rd=3 -> r3 stays valid=0, tag 0x11. Flush with simultaneous rename r3 -> r3 COMMIT and rename dropped.
